// File: rtl/btn_pkg.sv
// Shared definitions for the push-button pulse generator: FSM state encodings
// and default timing parameters.
package btn_pkg;

   typedef enum logic [2:0] {
      StIdle        = 3'd0,
      StPressWait   = 3'd1,
      StPressed     = 3'd2,
      StRepeat      = 3'd3,
      StReleaseWait = 3'd4
   } btn_state_e;

   localparam int unsigned DbCyclesDefault  = 4;
   localparam int unsigned RptDelayDefault  = 16;
   localparam int unsigned RptPeriodDefault = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by CLR.
module sync_2ff (
   input  logic CLK,
   input  logic CLR,
   input  logic D,
   output logic Q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = D;
      sync_d = meta_q;
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign Q = sync_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounces a raw push-button and emits single-cycle count-enable pulses on
// press, with optional auto-repeat while the button is held.
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int unsigned DB_CYCLES  = DbCyclesDefault,
   parameter int unsigned RPT_DELAY  = RptDelayDefault,
   parameter int unsigned RPT_PERIOD = RptPeriodDefault
) (
   input  logic CLK,
   input  logic CLR,
   input  logic BTN,
   input  logic RPT_EN,
   output logic E,
   output logic HELD
);

   localparam int unsigned CntW   = $clog2(DB_CYCLES);
   localparam int unsigned TmrMax = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int unsigned TmrW   = $clog2(TmrMax);

   localparam logic [CntW-1:0] CntLast    = CntW'(DB_CYCLES - 1);
   localparam logic [TmrW-1:0] DelayLast  = TmrW'(RPT_DELAY - 1);
   localparam logic [TmrW-1:0] PeriodLast = TmrW'(RPT_PERIOD - 1);

   logic btn_s;

   btn_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [TmrW-1:0] tmr_q, tmr_d;
   logic            e_q, e_d;
   logic            held_q, held_d;

   sync_2ff u_sync (
      .CLK (CLK),
      .CLR (CLR),
      .D   (BTN),
      .Q   (btn_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      e_d     = 1'b0;
      held_d  = held_q;

      case (state_q)
         StIdle: begin
            held_d = 1'b0;
            cnt_d  = '0;
            tmr_d  = '0;
            if (btn_s) begin
               state_d = StPressWait;
               cnt_d   = CntW'(1);
            end
         end

         StPressWait: begin
            if (!btn_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StPressed;
               e_d     = 1'b1;
               held_d  = 1'b1;
               cnt_d   = '0;
               tmr_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StPressed: begin
            // Release is checked first so it beats a coincident timer expiry.
            if (!btn_s) begin
               state_d = StReleaseWait;
               cnt_d   = CntW'(1);
            end else if (tmr_q == DelayLast) begin
               if (RPT_EN) begin
                  state_d = StRepeat;
                  e_d     = 1'b1;
                  tmr_d   = '0;
               end
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end

         StRepeat: begin
            if (!btn_s) begin
               state_d = StReleaseWait;
               cnt_d   = CntW'(1);
            end else if (!RPT_EN) begin
               state_d = StPressed;
               tmr_d   = '0;
            end else if (tmr_q == PeriodLast) begin
               e_d   = 1'b1;
               tmr_d = '0;
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end

         StReleaseWait: begin
            if (btn_s) begin
               state_d = StPressed;
               held_d  = 1'b1;
               cnt_d   = '0;
               tmr_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StIdle;
               held_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            tmr_d   = '0;
            held_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         tmr_q   <= '0;
         e_q     <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         e_q     <= e_d;
         held_q  <= held_d;
      end
   end

   assign E    = e_q;
   assign HELD = held_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen: per-cycle vector table plus hand-written
// reset sequences. Vector i drives inputs before edge i and checks outputs after it.
module tb_btn_pulse_gen;

   logic clk = 1'b0;
   logic clr;
   logic btn;
   logic rpt_en;
   logic e;
   logic held;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string name;
      int    idx;
      logic  btn;
      logic  rpt_en;
      logic  exp_e;
      logic  exp_held;
   } vec_t;

   vec_t vecs[$];

   btn_pulse_gen #(
      .DB_CYCLES  (4),
      .RPT_DELAY  (16),
      .RPT_PERIOD (8)
   ) dut (
      .CLK    (clk),
      .CLR    (clr),
      .BTN    (btn),
      .RPT_EN (rpt_en),
      .E      (e),
      .HELD   (held)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input string name, input int idx, input logic b,
                               input logic r, input logic ee, input logic h);
      vec_t v;
      v.name     = name;
      v.idx      = idx;
      v.btn      = b;
      v.rpt_en   = r;
      v.exp_e    = ee;
      v.exp_held = h;
      vecs.push_back(v);
   endfunction

   initial begin
      // Clean press, no repeat: E after edge 5, HELD 5..13, released at 14.
      for (int i = 0; i < 20; i++)
         add("clean", i, i < 9, 1'b0, i == 5, i >= 5 && i < 14);
      // Bounce: never accepted.
      for (int i = 0; i < 12; i++)
         add("bounce", i, i == 0 || i == 1 || i == 3 || i == 4, 1'b0, 1'b0, 1'b0);
      // Release glitch: one-cycle high during release debounce returns to PRESSED.
      for (int i = 0; i < 25; i++)
         add("glitch", i, i < 12 || i == 14, 1'b0, i == 5, i >= 5 && i < 20);
      // Timer saturates with repeat off; enabling later pulses at once. Release at
      // edge 38 beats the coincident repeat expiry.
      for (int i = 0; i < 46; i++)
         add("saturate", i, i < 36, i >= 30, i == 5 || i == 30, i >= 5 && i < 41);
      // Auto-repeat: pulses at 5, 21, 29, 37.
      for (int i = 0; i < 50; i++)
         add("repeat", i, i < 39, 1'b1, i == 5 || i == 21 || i == 29 || i == 37,
             i >= 5 && i < 44);
      // Repeat disabled while in REPEAT: back to PRESSED, no further pulses.
      for (int i = 0; i < 50; i++)
         add("rpt_off", i, i < 40, i < 24, i == 5 || i == 21, i >= 5 && i < 45);

      clr    = 1'b1;
      btn    = 1'b0;
      rpt_en = 1'b0;
      #2;
      check("reset_e", e, 1'b0);
      check("reset_held", held, 1'b0);

      btn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_e", e, 1'b0);
      check("reset_hold_held", held, 1'b0);
      @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);

      foreach (vecs[k]) begin
         @(negedge clk);
         btn    = vecs[k].btn;
         rpt_en = vecs[k].rpt_en;
         @(posedge clk);
         #1;
         check($sformatf("%s[%0d].E", vecs[k].name, vecs[k].idx), e, vecs[k].exp_e);
         check($sformatf("%s[%0d].HELD", vecs[k].name, vecs[k].idx), held, vecs[k].exp_held);
      end

      // Reset asserted mid-cycle while a repeat pulse is high.
      @(negedge clk);
      btn    = 1'b1;
      rpt_en = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("midrpt_pre_e", e, 1'b1);
      check("midrpt_pre_held", held, 1'b1);
      #2;
      clr = 1'b1;
      #1;
      check("midrpt_clr_e", e, 1'b0);
      check("midrpt_clr_held", held, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      // Button still high: a full fresh debounce is needed.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_clr[%0d].E", i), e, i == 5);
         check($sformatf("post_clr[%0d].HELD", i), held, i >= 5);
      end
      @(negedge clk);
      btn    = 1'b0;
      rpt_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("post_clr_release_held", held, 1'b0);
      check("post_clr_release_e", e, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
